// File: rtl/lsu_align_if.sv
// lsu_align_if: core request/response and word-memory bus of the aligner.
// slave = aligner side; master = core plus data memory side.
interface lsu_align_if #(
  parameter int WORD_AW = 18
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;
  logic               mem_req;
  logic               mem_we;
  logic [WORD_AW-1:0] mem_addr;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte/half/word load-store aligner onto a word-organised memory.
// Ports: clk, rst_n (sync, active low), bus (lsu_align_if.slave).
module lsu_align #(
  parameter int WORD_AW     = 18,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_align_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    WAIT,
    RESP
  } state_e;

  state_e state_q;

  logic               ready_q;
  logic               resp_valid_q;
  logic               resp_err_q;
  logic [31:0]        resp_rdata_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [WORD_AW-1:0] mem_addr_q;
  logic [3:0]         mem_be_q;
  logic [31:0]        mem_wdata_q;

  logic               we_q;
  logic               uns_q;
  logic               split_q;
  logic [1:0]         size_q;
  logic [1:0]         off_q;
  logic [WORD_AW-1:0] waddr_q;
  logic [3:0]         be1_q;
  logic [31:0]        wd1_q;
  logic [31:0]        rdata0_q;

  logic [1:0]         in_off;
  logic [2:0]         in_n;
  logic [3:0]         in_base;
  logic [7:0]         in_be;
  logic [63:0]        in_wd;
  logic               in_split;
  logic               in_err;
  logic [WORD_AW-1:0] in_waddr;

  // Lanes and data are placed across a two-word window: the low
  // word is part0 (or the whole access), the high word is part1.
  always_comb begin
    in_off   = bus.req_addr[1:0];
    in_waddr = bus.req_addr[WORD_AW+1:2];
    in_n     = 3'd1;
    in_base  = 4'b0001;
    case (bus.req_size)
      2'b01: begin
        in_n    = 3'd2;
        in_base = 4'b0011;
      end
      2'b10: begin
        in_n    = 3'd4;
        in_base = 4'b1111;
      end
      default: begin
        in_n    = 3'd1;
        in_base = 4'b0001;
      end
    endcase
    in_be    = {4'b0000, in_base} << in_off;
    in_wd    = {32'h0, bus.req_wdata} << {in_off, 3'b000};
    in_split = ({1'b0, in_off} + in_n) > 3'd4;
    in_err   = (bus.req_size == 2'b11) ||
               (!MISALIGN_EN && in_split);
  end

  logic [63:0] ld_pair;
  logic [31:0] ld_sh;
  logic [31:0] ld_ext;

  // In WAIT, mem_rdata holds the last word read: the only word of an
  // aligned load, or the upper word of a split one.
  always_comb begin
    ld_pair = split_q ? {bus.mem_rdata, rdata0_q}
                      : {32'h0, bus.mem_rdata};
    ld_sh   = ld_pair[{off_q, 3'b000} +: 32];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_sh[7]}}, ld_sh[7:0]};
      2'b01:   ld_ext = {{16{~uns_q & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      split_q      <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      waddr_q      <= '0;
      be1_q        <= '0;
      wd1_q        <= '0;
      rdata0_q     <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            off_q   <= in_off;
            waddr_q <= in_waddr;
            split_q <= in_split;
            be1_q   <= in_be[7:4];
            wd1_q   <= in_wd[63:32];
            if (in_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q     <= ACC0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= in_waddr;
              mem_be_q    <= in_be[3:0];
              mem_wdata_q <= in_wd[31:0];
            end
          end
        end
        ACC0: begin
          if (split_q) begin
            state_q     <= ACC1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_q;
            mem_addr_q  <= waddr_q + 1'b1;
            mem_be_q    <= be1_q;
            mem_wdata_q <= wd1_q;
          end else if (we_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        ACC1: begin
          if (we_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            rdata0_q <= bus.mem_rdata;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= ld_ext;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the single-cycle core datapath and the word-organised data memory.
- Accepts byte, half and word requests at any byte address with a valid/ready handshake.
- Issues word-aligned memory accesses with byte enables, splitting word-crossing requests into two accesses.
- Returns sign- or zero-extended load data and a store acknowledge.

Parameters:
- WORD_AW, 18, word-address width (memory depth 2^WORD_AW words; byte address bits [WORD_AW+1:2] used).
- MISALIGN_EN, 1, 1 = split word-crossing accesses; 0 = reject them with resp_err.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: load data or store acknowledge.
- resp_rdata  out  32  extended load data; holds until the next load response.
- resp_err  out  1  qualified by resp_valid; illegal size, or crossing with MISALIGN_EN=0.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  write enable.
- mem_addr  out  WORD_AW  word address.
- mem_be  out  4  byte-lane enables; bit i selects bits [8i+7:8i].
- mem_wdata  out  32  lane-positioned write data.
- mem_rdata  in  32  read data, valid the cycle after a mem_req with mem_we=0.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: the next edge aborts the request. No response is produced and no further mem_req is issued.
- All outputs are registered. req_ready=1 only in IDLE.
- Handshake: accept on req_valid & req_ready in cycle A. Request fields are latched at A; input changes after A are ignored.
- Definitions: o = req_addr[1:0], n = bytes (1, 2 or 4), w = req_addr[WORD_AW+1:2]. Split when o+n > 4.
- Split part0 uses lanes o..3 at w. Split part1 uses lanes 0..o+n-5 at (w+1) mod 2^WORD_AW; word address wraps to 0.
- Store data, part0: mem_wdata = req_wdata << 8o.
- Store data, part1: mem_wdata = req_wdata >> 8(4-o).
- Load data: form {rdata1, rdata0} >> 8o, keep the low n bytes, then extend per req_unsigned. Word loads ignore req_unsigned.
- FSM: IDLE -> ACC0 -> [ACC1] -> [WAIT] -> RESP -> IDLE. On error: IDLE -> RESP.
- IDLE: wait for handshake. Error request goes to RESP. Otherwise go to ACC0.
- ACC0: mem_req=1 for w with part0 (or full) lanes. Go to ACC1 if split; else go to WAIT for a load, RESP for a store.
- ACC1: mem_req=1 for w+1 with part1 lanes. For a load, capture mem_rdata as rdata0. Go to WAIT for a load, RESP for a store.
- WAIT: mem_req=0. Capture mem_rdata (rdata1 if split, else rdata0), then go to RESP.
- RESP: resp_valid=1 for one cycle; resp_rdata updates on load success only. Return to IDLE, so req_ready is 1 the following cycle.
- Latency, accept cycle A to resp_valid:
  - aligned store: A+2.
  - split store: A+3.
  - aligned load: A+3.
  - split load: A+4.
  - error: A+1.
- Error cases issue no mem_req. resp_rdata keeps its previous value. resp_err=1 only while resp_valid=1.
- mem_be and mem_we are 0 whenever mem_req=0.
- req_addr bits above WORD_AW+1 are ignored.

Test Plan:
- Reset, then LW at 0x100 with mem word 0x8899AABB. Expect mem_req at A+1 with mem_addr=0x40, mem_be=1111. Expect resp_valid at A+3 with resp_rdata=0x8899AABB, resp_err=0.
- LB at 0x103 (word 0x80112233), signed then unsigned. Expect resp_rdata=0xFFFFFF80, then 0x00000080.
- SH 0xBEEF at 0x203 (MISALIGN_EN=1). Expect word 0x80 with be=1000, wdata[31:24]=0xEF. Then word 0x81 with be=0001, wdata[7:0]=0xBE. Expect resp_valid at A+3.
- LW at 0x0FFFFE (WORD_AW=18), words 0x3FFFF=0x1122_3344 and 0x0=0x5566_7788. Expect mem_addr sequence 0x3FFFF, 0x00000 and resp_rdata=0x77881122.
- MISALIGN_EN=0: SW at 0x001, then req_size=11 at 0x0. Each gives resp_valid=1, resp_err=1 at A+1 with no mem_req. resp_rdata is unchanged.
- Assert rst_n=0 during ACC1 of a split load. Expect mem_req=0 and req_ready=1 after that edge, and resp_valid never pulses.
